// File: rtl/pe_window_sequencer.sv
// pe_window_sequencer: per-pixel window sequencer in front of the PE dataflow
// controller. Frames each output pixel with Start/Stop pulses around a burst
// of MAC_COUNT data-valid-gated MAC cycles. After each Stop it waits a few
// drain cycles, then moves to the next pixel until the layer is complete.
module pe_window_sequencer #(
  parameter  int KERNEL_W     = 3,
  parameter  int CHANNELS     = 3,
  parameter  int PIXEL_CNT_W  = 16,
  parameter  int DRAIN_CYCLES = 2,
  localparam int MAC_COUNT    = KERNEL_W * KERNEL_W * CHANNELS,
  localparam int MIDX_W       = (MAC_COUNT > 1) ? $clog2(MAC_COUNT) : 1
) (
  input  logic                   PEWS_Clk,
  input  logic                   PEWS_Reset,
  input  logic                   PEWS_Go,
  input  logic                   PEWS_Abort,
  input  logic [PIXEL_CNT_W-1:0] PEWS_Num_Pixels,
  input  logic                   PEWS_Data_Valid,
  output logic                   PEWS_Fetch_Req,
  output logic                   PEWS_Mac_Enable,
  output logic [MIDX_W-1:0]      PEWS_Mac_Index,
  output logic                   PEWS_Start_Routine,
  output logic                   PEWS_Stop_Routine,
  output logic [PIXEL_CNT_W-1:0] PEWS_Pixel_Index,
  output logic                   PEWS_Busy,
  output logic                   PEWS_Layer_Done
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [MIDX_W-1:0] MAC_LAST   = MIDX_W'(MAC_COUNT - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ACCUM = 3'd2,
    S_STOP  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PIXEL_CNT_W-1:0] num_q, num_d;
  logic [PIXEL_CNT_W-1:0] pix_q, pix_d;
  logic [MIDX_W-1:0]      mac_q, mac_d;
  logic [DRN_W-1:0]       drn_q, drn_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   fetch_q, fetch_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Next-state, counter updates and registered Moore outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    pix_d   = pix_q;
    mac_d   = mac_q;
    drn_d   = drn_q;

    if (PEWS_Abort && (state_q != S_IDLE)) begin
      // Abort drops everything without a Stop or Layer_Done
      state_d = S_IDLE;
      num_d   = '0;
      pix_d   = '0;
      mac_d   = '0;
      drn_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Abort held in IDLE masks a simultaneous Go
          if (PEWS_Go && !PEWS_Abort) begin
            num_d   = PEWS_Num_Pixels;
            pix_d   = '0;
            state_d = (PEWS_Num_Pixels == '0) ? S_DONE : S_START;
          end
        end
        S_START: begin
          mac_d   = '0;
          state_d = S_ACCUM;
        end
        S_ACCUM: begin
          // Index parks on the last element when the window completes
          if (PEWS_Data_Valid) begin
            if (mac_q == MAC_LAST) begin
              state_d = S_STOP;
            end else begin
              mac_d = mac_q + MIDX_W'(1);
            end
          end
        end
        S_STOP: begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (drn_q == DRAIN_LAST) begin
            if (pix_q == (num_q - PIXEL_CNT_W'(1))) begin
              state_d = S_DONE;
            end else begin
              pix_d   = pix_q + PIXEL_CNT_W'(1);
              state_d = S_START;
            end
          end else begin
            drn_d = drn_q + DRN_W'(1);
          end
        end
        S_DONE: begin
          // Leave IDLE with clean counters so idle outputs read zero
          pix_d   = '0;
          mac_d   = '0;
          drn_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    start_d = (state_d == S_START);
    stop_d  = (state_d == S_STOP);
    fetch_d = (state_d == S_ACCUM);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, counter and output registers with asynchronous clear
  always_ff @(posedge PEWS_Clk or posedge PEWS_Reset) begin
    if (PEWS_Reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      pix_q   <= '0;
      mac_q   <= '0;
      drn_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      fetch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      pix_q   <= pix_d;
      mac_q   <= mac_d;
      drn_q   <= drn_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      fetch_q <= fetch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign PEWS_Fetch_Req     = fetch_q;
  assign PEWS_Mac_Enable    = fetch_q & PEWS_Data_Valid;
  assign PEWS_Mac_Index     = mac_q;
  assign PEWS_Start_Routine = start_q;
  assign PEWS_Stop_Routine  = stop_q;
  assign PEWS_Pixel_Index   = pix_q;
  assign PEWS_Busy          = busy_q;
  assign PEWS_Layer_Done    = done_q;

endmodule

// File: tb/tb_pe_window_sequencer.sv
// Testbench for pe_window_sequencer (3x3 kernel, 3 channels, 2 drain cycles).
module tb_pe_window_sequencer;

  localparam int PW         = 16;
  localparam int MW         = 5;
  localparam int MAC        = 27;
  localparam int DRAIN      = 2;
  localparam int PIX_PERIOD = 1 + MAC + 1 + DRAIN;  // START + ACCUM + STOP + DRAIN
  localparam int MAXC       = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          abort;
  logic [PW-1:0] num;
  logic          dv;
  logic          fetch_req;
  logic          mac_en;
  logic [MW-1:0] mac_idx;
  logic          start_r;
  logic          stop_r;
  logic [PW-1:0] pix_idx;
  logic          busy;
  logic          layer_done;

  always #5 clk = ~clk;

  pe_window_sequencer #(
    .KERNEL_W(3), .CHANNELS(3), .PIXEL_CNT_W(PW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .PEWS_Clk(clk),
    .PEWS_Reset(rst),
    .PEWS_Go(go),
    .PEWS_Abort(abort),
    .PEWS_Num_Pixels(num),
    .PEWS_Data_Valid(dv),
    .PEWS_Fetch_Req(fetch_req),
    .PEWS_Mac_Enable(mac_en),
    .PEWS_Mac_Index(mac_idx),
    .PEWS_Start_Routine(start_r),
    .PEWS_Stop_Routine(stop_r),
    .PEWS_Pixel_Index(pix_idx),
    .PEWS_Busy(busy),
    .PEWS_Layer_Done(layer_done)
  );

  typedef struct {
    int num_pix;
    int vmode;      // 0: always valid, 1: valid on even cycles, 2: valid every 3rd cycle
    bit go_again;   // pulse Go again mid-layer (must be ignored)
    int done_cyc;   // cycle of Layer_Done, Go sampled at the end of cycle 0
  } vec_t;

  typedef struct {
    int starts;
    int stops;
    int macs;
    int dones;
    int first_start;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic logic valid_at(input int m, input int c);
    case (m)
      0:       return 1'b1;
      1:       return (c % 2) == 0;
      default: return (c % 3) == 0;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fetch"}, fetch_req, 0);
    chk({tag, "_mac_en"}, mac_en, 0);
    chk({tag, "_start"}, start_r, 0);
    chk({tag, "_stop"}, stop_r, 0);
    chk({tag, "_done"}, layer_done, 0);
    chk({tag, "_pix"}, pix_idx, 0);
    chk({tag, "_mac_idx"}, mac_idx, 0);
  endtask

  // One full layer: push the expectation, drive Go, observe until Busy drops, pop and compare
  task automatic run_layer(input vec_t v);
    exp_t e;
    exp_t got;
    int   last_start;
    int   win;
    int   idle_cyc;
    e.starts      = v.num_pix;
    e.stops       = v.num_pix;
    e.macs        = v.num_pix * MAC;
    e.dones       = 1;
    e.first_start = (v.num_pix > 0) ? 1 : -1;
    e.done_cyc    = v.done_cyc;
    got = '{default: 0};
    got.first_start = -1;
    got.done_cyc    = -1;
    last_start = -1;
    win        = 0;
    idle_cyc   = -1;

    @(posedge clk); #1;
    sb.push_back(e);
    go  = 1'b1;
    num = PW'(v.num_pix);
    dv  = valid_at(v.vmode, 0);
    #1;
    for (int c = 1; c <= MAXC; c++) begin
      @(posedge clk); #1;
      go  = v.go_again && (c == 10);
      num = PW'(v.num_pix + 4);
      dv  = valid_at(v.vmode, c);
      #1;
      chk("start_stop_excl", start_r & stop_r, 0);
      chk("mac_gate", mac_en, fetch_req & dv);
      if (start_r) begin
        got.starts++;
        if (got.first_start < 0) got.first_start = c;
        chk("start_pix", pix_idx, got.starts - 1);
        if (v.vmode == 0 && last_start >= 0) chk("start_gap", c - last_start, PIX_PERIOD);
        last_start = c;
        win = 0;
      end
      if (mac_en) begin
        chk("mac_idx", mac_idx, win);
        win++;
        got.macs++;
      end
      if (stop_r) begin
        got.stops++;
        chk("stop_after_window", win, MAC);
      end
      if (layer_done) begin
        got.dones++;
        if (got.done_cyc < 0) got.done_cyc = c;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
    end
    go = 1'b0;
    dv = 1'b0;

    e = sb.pop_front();
    chk("starts", got.starts, e.starts);
    chk("stops", got.stops, e.stops);
    chk("macs", got.macs, e.macs);
    chk("dones", got.dones, e.dones);
    chk("first_start", got.first_start, e.first_start);
    chk("done_cycle", got.done_cyc, e.done_cyc);
    chk("idle_cycle", idle_cyc, e.done_cyc + 1);
    $display("layer np=%0d mode=%0d go_again=%0d: starts=%0d stops=%0d macs=%0d done@%0d idle@%0d",
             v.num_pix, v.vmode, v.go_again, got.starts, got.stops, got.macs, got.done_cyc, idle_cyc);
  endtask

  // Abort on the 10th MAC of a 2-pixel layer, then abort+go in IDLE, then a fresh layer
  task automatic abort_seq();
    int   macs;
    int   late;
    vec_t v;
    macs = 0;
    late = 0;
    @(posedge clk); #1;
    go = 1'b1; num = PW'(2); dv = 1'b1;
    #1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      go    = 1'b0;
      abort = (c == 11);
      #1;
      if (mac_en) macs++;
    end
    chk("abort_at_mac", macs, 10);
    @(posedge clk); #1;
    abort = 1'b0;
    #1;
    chk_all_zero("after_abort");
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      late += int'(stop_r) + int'(layer_done) + int'(busy);
    end
    chk("abort_quiet", late, 0);
    $display("abort at 10th MAC: macs=%0d late_activity=%0d", macs, late);

    @(posedge clk); #1;
    go = 1'b1; abort = 1'b1; num = PW'(1);
    @(posedge clk); #1;
    go = 1'b0; abort = 1'b0;
    #1;
    chk("abort_go_idle_busy", busy, 0);
    chk("abort_go_idle_start", start_r, 0);
    $display("abort+go in idle: busy=%0d", busy);

    v = '{num_pix: 1, vmode: 0, go_again: 1'b0, done_cyc: 32};
    run_layer(v);
  endtask

  // Asynchronous reset landing between edges while in DRAIN
  task automatic reset_drain_seq();
    @(posedge clk); #1;
    go = 1'b1; num = PW'(1); dv = 1'b1;
    #1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      go = 1'b0;
      #1;
      if (c == 29) chk("stop_at_29", stop_r, 1);
      if (c == 30) chk("drain_busy", busy, 1);
    end
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;
    @(posedge clk); #2;
    chk("post_reset_busy", busy, 0);
    $display("reset mid-drain: busy=%0d mac_idx=%0d pix=%0d", busy, mac_idx, pix_idx);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{num_pix: 1, vmode: 0, go_again: 1'b0, done_cyc: 32};
    vecs[1] = '{num_pix: 1, vmode: 1, go_again: 1'b0, done_cyc: 58};
    vecs[2] = '{num_pix: 3, vmode: 0, go_again: 1'b0, done_cyc: 94};
    vecs[3] = '{num_pix: 0, vmode: 0, go_again: 1'b0, done_cyc: 1};
    vecs[4] = '{num_pix: 2, vmode: 2, go_again: 1'b0, done_cyc: 169};
    vecs[5] = '{num_pix: 1, vmode: 0, go_again: 1'b1, done_cyc: 32};

    rst = 1'b1; go = 1'b0; abort = 1'b0; num = '0; dv = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;

    for (int i = 0; i < 6; i++) run_layer(vecs[i]);
    abort_seq();
    reset_drain_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 expected less");
    $fatal(1);
  end

endmodule
